// File: rtl/seu_counter_arbiter_pkg.sv
// seu_counter_arbiter_pkg: shared readout FSM state type and index-width helper
package seu_counter_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ACK, WAIT} rd_state_e;

    // Index width for n items, never below 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr_i
// Ports: pend_i pending vector, ptr_i search start index, grant_o one-hot grant (all zero when idle)
module rr_arbiter import seu_counter_arbiter_pkg::*; #(
    parameter int N = 4
) (
    input  logic [N-1:0]          pend_i,
    input  logic [clog2(N)-1:0]   ptr_i,
    output logic [N-1:0]          grant_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && pend_i[(int'(ptr_i) + k) % N]) begin
                grant_o[(int'(ptr_i) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seu_counter_arbiter.sv
// seu_counter_arbiter: per-source SEU event counters fed through a round-robin arbiter, with a four-phase readout port
// Ports: clk, rstn (async active-low); tmrError per-source error strobes; seuCountRst soft clear;
//        rdReq/rdSel/rdClr readout request, index and clear-on-read; rdAck/rdData readout response;
//        seuCount saturating total; lostEvent sticky per-source dropped-event flags
module seu_counter_arbiter import seu_counter_arbiter_pkg::*; #(
    parameter int NSRC        = 4,
    parameter int SEUCNTWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NSRC-1:0]          tmrError,
    input  logic                     seuCountRst,
    input  logic                     rdReq,
    input  logic [clog2(NSRC)-1:0]   rdSel,
    input  logic                     rdClr,
    output logic                     rdAck,
    output logic [SEUCNTWIDTH-1:0]   rdData,
    output logic [SEUCNTWIDTH-1:0]   seuCount,
    output logic [NSRC-1:0]          lostEvent
);

    localparam int IW = clog2(NSRC);
    localparam logic [SEUCNTWIDTH-1:0] CMAX = '1;

    rd_state_e              st_q, st_d;
    logic [NSRC-1:0]        pend_q, pend_d, lost_q, lost_d, grant;
    logic [IW-1:0]          ptr_q, ptr_d, gidx;
    logic [SEUCNTWIDTH-1:0] cnt_q [NSRC];
    logic [SEUCNTWIDTH-1:0] cnt_d [NSRC];
    logic [SEUCNTWIDTH-1:0] tot_q, tot_d, data_q, data_d, sel_val;
    logic                   rd_start;

    rr_arbiter #(.N(NSRC)) u_arb (
        .pend_i  (pend_q),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Out-of-range rdSel matches no source, so the snapshot reads as zero.
    always_comb begin
        gidx = '0;
        sel_val = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) gidx = IW'(i);
            if (int'(rdSel) == i) sel_val = cnt_q[i];
        end
    end

    always_comb begin
        rd_start = (st_q == IDLE) && rdReq;
        st_d = rd_start ? ACK : (st_q == ACK) ? WAIT : (st_q == WAIT && !rdReq) ? IDLE : st_q;
        data_d = rd_start ? sel_val : data_q;
    end

    // A strobe on the grant edge re-arms pending; only an ungranted repeat is lost.
    always_comb begin
        pend_d = (pend_q & ~grant) | tmrError;
        lost_d = lost_q | (tmrError & pend_q & ~grant);
        ptr_d = (|grant) ? ((int'(gidx) == NSRC - 1) ? '0 : gidx + 1'b1) : ptr_q;
        tot_d = (|grant && tot_q != CMAX) ? tot_q + 1'b1 : tot_q;
        for (int i = 0; i < NSRC; i++) begin
            cnt_d[i] = (grant[i] && cnt_q[i] != CMAX) ? cnt_q[i] + 1'b1 : cnt_q[i];
            // Clear-on-read keeps an event granted on the same edge.
            if (rd_start && rdClr && int'(rdSel) == i) cnt_d[i] = SEUCNTWIDTH'(grant[i]);
        end
        if (seuCountRst) begin
            pend_d = '0;
            lost_d = '0;
            ptr_d = '0;
            tot_d = '0;
            for (int i = 0; i < NSRC; i++) cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q <= IDLE;
            pend_q <= '0;
            lost_q <= '0;
            ptr_q <= '0;
            tot_q <= '0;
            data_q <= '0;
            for (int i = 0; i < NSRC; i++) cnt_q[i] <= '0;
        end else begin
            st_q <= st_d;
            pend_q <= pend_d;
            lost_q <= lost_d;
            ptr_q <= ptr_d;
            tot_q <= tot_d;
            data_q <= data_d;
            for (int i = 0; i < NSRC; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rdAck = (st_q == ACK);
    assign rdData = data_q;
    assign seuCount = tot_q;
    assign lostEvent = lost_q;

endmodule

// File: doc/seu_counter_arbiter.md
SEU_COUNTER_ARBITER -- requirements
Module: seu_counter_arbiter

Interface
REQ-001 Parameter NSRC, default 4: number of TMR error sources (voter groups) sharing the counter bank; legal range 2..16.
REQ-002 Parameter SEUCNTWIDTH, default 8: width of each per-source counter and of the total counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rstn, input, 1: asynchronous, active-low reset.
REQ-005 Port tmrError, input, NSRC: per-source voter mismatch strobes, sampled on every clk edge.
REQ-006 Port seuCountRst, input, 1: synchronous active-high soft clear of all counters, pending bits and flags.
REQ-007 Port rdReq, input, 1: readout request, four-phase level.
REQ-008 Port rdSel, input, clog2(NSRC): counter index to read; held stable while rdReq is high.
REQ-009 Port rdClr, input, 1: when high, the read clears the selected counter.
REQ-010 Port rdAck, output, 1: readout acknowledge.
REQ-011 Port rdData, output, SEUCNTWIDTH: snapshot of the selected counter, valid while rdAck is high.
REQ-012 Port seuCount, output, SEUCNTWIDTH: saturating total of all counted events.
REQ-013 Port lostEvent, output, NSRC: sticky per-source flag, set when an event is dropped.

Function
REQ-014 pending[i] sets on the edge where tmrError[i]=1; it clears on the edge where source i is granted, unless tmrError[i]=1 on that same edge, in which case it stays set.
REQ-015 If tmrError[i]=1 while pending[i]=1 and i is not granted on that edge, lostEvent[i] sets and stays set.
REQ-016 Grant: at most one source per cycle, chosen round-robin among pending bits, searching upward from pointer ptr.
- ptr resets to 0.
- After a grant to i, ptr becomes (i+1) mod NSRC.
- With no pending bits, ptr holds.
REQ-017 Granted source i: cnt[i] and seuCount each increment by 1 on the same edge; each saturates at 2^SEUCNTWIDTH-1 with no wrap.
REQ-018 Latency: tmrError pulse at edge t sets pending at edge t; an uncontended source is counted at edge t+1.
REQ-019 Readout FSM has three states: IDLE, ACK, WAIT.
- IDLE->ACK when rdReq=1: rdData captures cnt[rdSel] and rdAck=1 from the next cycle.
- ACK->WAIT after exactly one cycle: rdAck=0, rdData holds.
- WAIT->IDLE when rdReq=0.
REQ-020 Read clear, on the IDLE->ACK edge with rdClr=1: cnt[rdSel] becomes 0, or 1 if source rdSel is granted on that same edge, so no event is lost; rdData gets the pre-increment value.
REQ-021 seuCount is never cleared by a read.
REQ-022 seuCountRst=1 clears every cnt, pending bit, lostEvent bit and seuCount, and sets ptr=0.
- It has priority over grant and read clear on the same edge.
- The readout FSM is not affected.
REQ-023 rdSel >= NSRC returns rdData=0 and still completes the handshake.

Reset
REQ-024 While rstn=0, all outputs SHALL be 0: rdAck, rdData, seuCount, lostEvent.
REQ-025 While rstn=0, all internal state SHALL be cleared: cnt, pending, ptr=0, FSM=IDLE.
REQ-026 Reset asserted mid-handshake returns the FSM to IDLE; after release, a still-high rdReq starts a new read.

Structure
REQ-027 A shared package holds:
- the readout FSM state enum {IDLE, ACK, WAIT};
- the index-width function clog2.
REQ-028 The round-robin arbiter is one sub-module, rr_arbiter: pending vector and ptr in, one-hot grant out, purely combinational.
REQ-029 All state registers are plain flops with no vendor primitives, so the TMR tool can triplicate them.

Verification
REQ-030 NSRC=4; pulse tmrError=4'b1111 for one cycle -> grants go to 0,1,2,3 on four consecutive edges; seuCount=4; each cnt=1; lostEvent=0.
REQ-031 Hold tmrError[2]=1 for 3 cycles while sources 0 and 1 are pending -> lostEvent[2]=1; cnt[2] ends at 1 or 2 according to the REQ-014/REQ-015 trace.
REQ-032 Preload cnt[1]=5; set rdReq=1, rdSel=1, rdClr=1 on the same edge where source 1 is granted -> rdData=5 and cnt[1]=1 afterwards; rdAck high for exactly one cycle.
REQ-033 With SEUCNTWIDTH=4, apply 20 events on source 0 -> cnt[0]=15 and seuCount=15, no wrap.
REQ-034 Drop rstn in the ACK state -> rdAck=0 immediately and all counters 0; after release with rdReq still high -> a new ACK follows one cycle later.
REQ-035 Assert seuCountRst on the same edge as a grant and a read clear -> all counters 0, pending 0, ptr 0.
